// File: rtl/ga25_row_shifter.sv
// ga25_row_shifter
// ----------------
// Tile-row pixel shifter for the GA25 tilemap pipeline. Planar tile rows are
// unpacked into packed pixels when they are pushed into a 2-entry queue. A
// current-row register is reloaded from the queue head at every row boundary.
// The boundary position is the pixel counter plus the fine-scroll offset. One
// packed pixel per ce_pix is emitted with palette, priority and opacity.
//
// Ports
//   clk, reset_n   : system clock, asynchronous active-low reset
//   ce_pix         : pixel clock enable (advances counter / shifter)
//   line_start     : flush queue, realign counter, invalidate current row,
//                    clear sticky flags (wins over push and boundary)
//   offset         : fine-scroll offset, sampled on every ce_pix
//   load_valid     : a row is offered on row/reverse/palette/prio
//   load_ready     : queue holds fewer than two rows
//   reverse        : horizontal flip of the offered row
//   row            : planar row, plane p at row[p*PIX +: PIX]
//   palette, prio  : attributes of the offered row
//   color_out      : {current palette, current pixel}
//   prio_out       : priority of the current row
//   opaque_out     : current pixel non-zero and from a valid row
//   underrun       : sticky, boundary found the queue empty
//   overflow       : sticky, a row was offered to a full queue and dropped
module ga25_row_shifter #(
   parameter int BPP    = 4,
   parameter int PIX    = 8,
   parameter int PAL_W  = 4,
   parameter int PRIO_W = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ce_pix,
   input  logic                     line_start,
   input  logic [$clog2(PIX)-1:0]   offset,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic                     reverse,
   input  logic [BPP*PIX-1:0]       row,
   input  logic [PAL_W-1:0]         palette,
   input  logic [PRIO_W-1:0]        prio,
   output logic [PAL_W+BPP-1:0]     color_out,
   output logic [PRIO_W-1:0]        prio_out,
   output logic                     opaque_out,
   output logic                     underrun,
   output logic                     overflow
);

   localparam int CW = $clog2(PIX);
   localparam int PW = BPP * PIX;
   localparam int EW = PW + PAL_W + PRIO_W;

   // PIX is a power of two, so PIX-1 is all ones in CW bits.
   localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   // Queue entry layout: {prio, palette, packed pixels}; pixel i at [i*BPP +: BPP].
   function automatic logic [PW-1:0] unpack_row(input logic [PW-1:0] r, input logic rev);
      logic [PW-1:0] o;
      o = {PW{1'b0}};
      for (int i = 0; i < PIX; i++) begin
         for (int p = 0; p < BPP; p++) begin
            if (rev) begin
               o[i*BPP + p] = r[p*PIX + i];
            end else begin
               o[i*BPP + p] = r[p*PIX + (PIX - 1 - i)];
            end
         end
      end
      return o;
   endfunction

   logic [CW-1:0]     cnt_q,        cnt_d;
   logic [1:0]        count_q,      count_d;
   logic [EW-1:0]     q0_q,         q0_d;
   logic [EW-1:0]     q1_q,         q1_d;
   logic [PW-1:0]     cur_pix_q,    cur_pix_d;
   logic [PAL_W-1:0]  pal_cur_q,    pal_cur_d;
   logic [PRIO_W-1:0] prio_cur_q,   prio_cur_d;
   logic              valid_cur_q,  valid_cur_d;
   logic              underrun_q,   underrun_d;
   logic              overflow_q,   overflow_d;

   logic [CW-1:0]     pos_s;
   logic              boundary_s;
   logic              pop_s;
   logic              push_ok_s;
   logic [1:0]        lvl_s;
   logic [EW-1:0]     entry_in_s;
   logic [EW-1:0]     q0_after_s;

   // Next-state logic for counter, queue, current row and sticky flags.
   always_comb begin
      cnt_d       = cnt_q;
      count_d     = count_q;
      q0_d        = q0_q;
      q1_d        = q1_q;
      cur_pix_d   = cur_pix_q;
      pal_cur_d   = pal_cur_q;
      prio_cur_d  = prio_cur_q;
      valid_cur_d = valid_cur_q;
      underrun_d  = underrun_q;
      overflow_d  = overflow_q;

      entry_in_s  = {prio, palette, unpack_row(row, reverse)};
      pos_s       = cnt_q + offset;
      boundary_s  = ce_pix && (pos_s == CNT_LAST);
      pop_s       = boundary_s && (count_q != 2'd0);
      // A pop frees a slot before the push is considered, so a push into a
      // full queue that is popping in the same cycle is still accepted.
      push_ok_s   = load_valid && ((count_q != 2'd2) || pop_s);
      lvl_s       = count_q - {1'b0, pop_s};
      q0_after_s  = pop_s ? q1_q : q0_q;

      if (line_start) begin
         cnt_d       = {CW{1'b0}};
         count_d     = 2'd0;
         valid_cur_d = 1'b0;
         underrun_d  = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         if (ce_pix) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end

         if (boundary_s) begin
            if (pop_s) begin
               cur_pix_d   = q0_q[PW-1:0];
               pal_cur_d   = q0_q[PW +: PAL_W];
               prio_cur_d  = q0_q[PW+PAL_W +: PRIO_W];
               valid_cur_d = 1'b1;
            end else begin
               cur_pix_d   = {PW{1'b0}};
               valid_cur_d = 1'b0;
               underrun_d  = 1'b1;
            end
         end else if (ce_pix) begin
            cur_pix_d = {{BPP{1'b0}}, cur_pix_q[PW-1:BPP]};
         end else begin
            cur_pix_d = cur_pix_q;
         end

         // Queue: the pushed row is written behind whatever survives the pop,
         // so a pop from an empty queue never sees the row pushed alongside it.
         q0_d = q0_after_s;
         if (push_ok_s) begin
            if (lvl_s == 2'd0) begin
               q0_d = entry_in_s;
            end else begin
               q1_d = entry_in_s;
            end
            count_d = lvl_s + 2'd1;
         end else begin
            count_d = lvl_s;
         end

         if (load_valid && !push_ok_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= {CW{1'b0}};
         count_q     <= 2'd0;
         q0_q        <= {EW{1'b0}};
         q1_q        <= {EW{1'b0}};
         cur_pix_q   <= {PW{1'b0}};
         pal_cur_q   <= {PAL_W{1'b0}};
         prio_cur_q  <= {PRIO_W{1'b0}};
         valid_cur_q <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         count_q     <= count_d;
         q0_q        <= q0_d;
         q1_q        <= q1_d;
         cur_pix_q   <= cur_pix_d;
         pal_cur_q   <= pal_cur_d;
         prio_cur_q  <= prio_cur_d;
         valid_cur_q <= valid_cur_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
      end
   end

   assign load_ready = (count_q < 2'd2);
   assign color_out  = {pal_cur_q, cur_pix_q[BPP-1:0]};
   assign prio_out   = prio_cur_q;
   assign opaque_out = valid_cur_q && (|cur_pix_q[BPP-1:0]);
   assign underrun   = underrun_q;
   assign overflow   = overflow_q;

endmodule
